// File: rtl/irq_enc_pkg.sv
// Shared constants and types for the 16-to-4 request encoder.
// The round-robin option is selected by IRQ_ENC_ROUND_ROBIN_EN in irq_enc16x4.
package irq_enc_pkg;

    localparam int unsigned N_REQ  = 16;
    localparam int unsigned CODE_W = 4;

    typedef logic [N_REQ-1:0]  req_vec_t;
    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_e;

    function automatic req_vec_t onehot(code_t c);
        req_vec_t v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_enc16x4.sv
// Combinational 16-to-4 priority encoder: searches downward from start,
// wrapping 0 -> 15, and returns the first set index.
module prio_enc16x4 (
    input  logic [15:0] vec,
    input  logic [3:0]  start,
    output logic [3:0]  code,
    output logic        any_o
);
    import irq_enc_pkg::*;

    code_t idx;

    always_comb begin
        code  = '0;
        any_o = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = start - code_t'(i);
            if (!any_o && vec[idx]) begin
                code  = idx;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_enc16x4.sv
// Sequential 16-to-4 request encoder with sticky pending bits and a valid/ready output.
// Define IRQ_ENC_ROUND_ROBIN_EN for rotating priority; default is fixed highest-index-wins.
module irq_enc16x4 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [3:0]  code_o,
    output logic [15:0] pending_o,
    output logic        lost_o
);
    import irq_enc_pkg::*;

    state_e   state_q, state_d;
    req_vec_t req_q, pending_q, pending_d;
    req_vec_t rise, clr, nxt;
    code_t    code_q, code_d, enc_code, start;
    logic     armed_q, lost_q, lost_d, any, accept;

    assign accept = (state_q == StHold) && ready_i;

    // The first edge after reset only samples req_i, so lines held high through
    // reset must fall and rise again before they count as a new event.
    assign rise      = armed_q ? (req_i & ~req_q) : '0;
    assign clr       = accept ? onehot(code_q) : '0;
    assign nxt       = pending_q & ~clr;
    assign pending_d = nxt | rise;
    assign lost_d    = |(rise & pending_q & ~clr);

`ifdef IRQ_ENC_ROUND_ROBIN_EN
    code_t ptr_q;

    // The accepted source drops to lowest priority already for the back-to-back pick.
    assign start = accept ? (code_q - 4'd1) : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 4'hF;
        end else if (accept) begin
            ptr_q <= code_q - 4'd1;
        end
    end
`else
    assign start = 4'hF;
`endif

    prio_enc16x4 u_prio (
        .vec   (nxt),
        .start (start),
        .code  (enc_code),
        .any_o (any)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            StIdle: begin
                if (any) begin
                    code_d  = enc_code;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (ready_i) begin
                    if (any) begin
                        code_d = enc_code;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            req_q     <= '0;
            pending_q <= '0;
            code_q    <= '0;
            lost_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_i;
            pending_q <= pending_d;
            code_q    <= code_d;
            lost_q    <= lost_d;
            armed_q   <= 1'b1;
        end
    end

    assign valid_o   = (state_q == StHold);
    assign code_o    = code_q;
    assign pending_o = pending_q;
    assign lost_o    = lost_q;

endmodule

// File: tb/tb_irq_enc16x4.sv
// Directed self-checking bench for irq_enc16x4.
// Round-robin scenarios run only when IRQ_ENC_ROUND_ROBIN_EN is defined.
module tb_irq_enc16x4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic        ready = 1'b0;
    logic        valid;
    logic [3:0]  code;
    logic [15:0] pending;
    logic        lost;

    int checks   = 0;
    int failures = 0;

    irq_enc16x4 dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .ready_i   (ready),
        .valid_o   (valid),
        .code_o    (code),
        .pending_o (pending),
        .lost_o    (lost)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, then let the arming edge pass with all requests low.
    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req   = '0;
        ready = 1'b0;
        tick();
        tick();
        checks++;
        if (valid !== 1'b0 || code !== 4'd0 || pending !== 16'h0000 || lost !== 1'b0) begin
            failures++;
            $display("FAIL reset_held: valid=%b code=%0d pending=%h lost=%b, want all 0",
                     valid, code, pending, lost);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (valid !== 1'b0 || pending !== 16'h0000 || lost !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: valid=%b pending=%h lost=%b, want 0 0000 0",
                     valid, pending, lost);
        end
    endtask

    task automatic test_single();
        do_reset();
        req[5] = 1'b1;
        tick();
        checks++;
        if (pending !== 16'h0020 || valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pend: pending=%h valid=%b, want 0020 0", pending, valid);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 4'd5) begin
            failures++;
            $display("FAIL single_grant: valid=%b code=%0d, want 1 5", valid, code);
        end
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL single_accept: valid=%b pending=%h, want 0 0000", valid, pending);
        end
        ready = 1'b0;
        req   = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_codes [3];
        exp_codes[0] = 4'd12;
        exp_codes[1] = 4'd9;
        exp_codes[2] = 4'd3;
        do_reset();
        req   = 16'h1208;
        ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid !== 1'b1 || code !== exp_codes[i]) begin
                failures++;
                $display("FAIL b2b_code%0d: valid=%b code=%0d, want 1 %0d",
                         i, valid, code, exp_codes[i]);
            end
            tick();
        end
        checks++;
        if (valid !== 1'b0 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL b2b_drain: valid=%b pending=%h, want 0 0000", valid, pending);
        end
        ready = 1'b0;
        req   = '0;
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        req = 16'h0010;
        tick();
        tick();
        req = 16'h4010;
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 4'd4 || pending !== 16'h4010) begin
            failures++;
            $display("FAIL hold_stable: valid=%b code=%0d pending=%h, want 1 4 4010",
                     valid, code, pending);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 4'd4) begin
            failures++;
            $display("FAIL hold_no_preempt: valid=%b code=%0d, want 1 4", valid, code);
        end
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 4'd14) begin
            failures++;
            $display("FAIL hold_next: valid=%b code=%0d, want 1 14", valid, code);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL hold_drain: valid=%b pending=%h, want 0 0000", valid, pending);
        end
        ready = 1'b0;
        req   = '0;
        tick();
    endtask

    task automatic test_rearm_on_accept();
        do_reset();
        req[7] = 1'b1;
        tick();
        tick();
        req[7] = 1'b0;
        tick();
        req[7] = 1'b1;
        ready  = 1'b1;
        tick();
        checks++;
        if (pending !== 16'h0080 || lost !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL rearm_keep: pending=%h lost=%b valid=%b, want 0080 0 0",
                     pending, lost, valid);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 4'd7 || lost !== 1'b0) begin
            failures++;
            $display("FAIL rearm_reissue: valid=%b code=%0d lost=%b, want 1 7 0",
                     valid, code, lost);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL rearm_drain: valid=%b pending=%h, want 0 0000", valid, pending);
        end
        ready = 1'b0;
        req   = '0;
        tick();
    endtask

    task automatic test_lost();
        do_reset();
        req[2] = 1'b1;
        tick();
        tick();
        req[2] = 1'b0;
        tick();
        checks++;
        if (lost !== 1'b0) begin
            failures++;
            $display("FAIL lost_quiet: lost=%b, want 0", lost);
        end
        req[2] = 1'b1;
        tick();
        checks++;
        if (lost !== 1'b1 || pending !== 16'h0004) begin
            failures++;
            $display("FAIL lost_pulse: lost=%b pending=%h, want 1 0004", lost, pending);
        end
        tick();
        checks++;
        if (lost !== 1'b0 || valid !== 1'b1 || code !== 4'd2) begin
            failures++;
            $display("FAIL lost_one_cycle: lost=%b valid=%b code=%0d, want 0 1 2",
                     lost, valid, code);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        req   = '0;
        tick();
    endtask

`ifdef IRQ_ENC_ROUND_ROBIN_EN
    task automatic test_round_robin();
        do_reset();
        req   = 16'hFFFF;
        ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (valid !== 1'b1 || code !== 4'(15 - i)) begin
                failures++;
                $display("FAIL rr_sweep%0d: valid=%b code=%0d, want 1 %0d",
                         i, valid, code, 15 - i);
            end
            tick();
        end
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_sweep_end: valid=%b, want 0", valid);
        end
        ready = 1'b0;
        req   = '0;
        tick();
        req = 16'h8001;
        tick();
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 4'd15) begin
            failures++;
            $display("FAIL rr_wrap_ptr15: valid=%b code=%0d, want 1 15", valid, code);
        end
        do_reset();
        req = 16'h0200;
        tick();
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        req   = '0;
        tick();
        req = 16'h8008;
        tick();
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 4'd3) begin
            failures++;
            $display("FAIL rr_ptr8: valid=%b code=%0d, want 1 3", valid, code);
        end
        req = '0;
        tick();
    endtask
`endif

    task automatic test_reset_mid_hold();
        do_reset();
        req = 16'hFFFF;
        tick();
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 4'd15 || pending !== 16'hFFFF) begin
            failures++;
            $display("FAIL midrst_pre: valid=%b code=%0d pending=%h, want 1 15 ffff",
                     valid, code, pending);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || code !== 4'd0 || pending !== 16'h0000 || lost !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: valid=%b code=%0d pending=%h lost=%b, want all 0",
                     valid, code, pending, lost);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (valid !== 1'b0 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_no_retrigger: valid=%b pending=%h, want 0 0000",
                     valid, pending);
        end
        req = 16'hFFFE;
        tick();
        req = 16'hFFFF;
        tick();
        checks++;
        if (pending !== 16'h0001) begin
            failures++;
            $display("FAIL midrst_reedge: pending=%h, want 0001", pending);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 4'd0) begin
            failures++;
            $display("FAIL midrst_grant: valid=%b code=%0d, want 1 0", valid, code);
        end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_rearm_on_accept();
        test_lost();
`ifdef IRQ_ENC_ROUND_ROBIN_EN
        test_round_robin();
`endif
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
